// File: rtl/redux_pkg.sv
// rtl/redux_pkg.sv - shared opcodes, instruction field positions and FSM states for the REDUX-V execute stage
package redux_pkg;

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    localparam int OP_MSB = 7;
    localparam int OP_LSB = 5;
    localparam int RA_MSB = 4;
    localparam int RA_LSB = 3;
    localparam int RSV_BIT = 2;
    localparam int RB_MSB = 1;
    localparam int RB_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

endpackage

// File: rtl/redux_regfile.sv
// rtl/redux_regfile.sv - REGS x BITS register file, two combinational reads, one synchronous write
module redux_regfile #(
    parameter int BITS = 8,
    parameter int REGS = 4,
    parameter int RW   = $clog2(REGS)
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            we,
    input  logic [RW-1:0]   waddr,
    input  logic [BITS-1:0] wdata,
    input  logic [RW-1:0]   raddr_a,
    input  logic [RW-1:0]   raddr_b,
    output logic [BITS-1:0] rdata_a,
    output logic [BITS-1:0] rdata_b
);

    logic [BITS-1:0] regs [REGS];

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/redux_exec.sv
// rtl/redux_exec.sv - REDUX-V execute-stage sequencer driving the combinational ULA
module redux_exec
    import redux_pkg::*;
#(
    parameter int OP   = 3,
    parameter int BITS = 8,
    parameter int REGS = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    instr_valid_in,
    output logic                    instr_ready_out,
    input  logic [7:0]              instr_in,
    input  logic                    load_en_in,
    input  logic [$clog2(REGS)-1:0] load_reg_in,
    input  logic [BITS-1:0]         load_data_in,
    output logic [OP-1:0]           ula_op_out,
    output logic [BITS-1:0]         ula_a_out,
    output logic [BITS-1:0]         ula_b_out,
    input  logic [BITS-1:0]         ula_result_in,
    output logic                    wb_valid_out,
    output logic [$clog2(REGS)-1:0] wb_reg_out,
    output logic [BITS-1:0]         wb_data_out,
    output logic                    busy_out
);

    localparam int RW = $clog2(REGS);

    state_e          state, state_nx;
    logic            accept;
    logic [RW-1:0]   ra_f, rb_f, ra_q;
    logic            rf_we;
    logic [RW-1:0]   rf_waddr;
    logic [BITS-1:0] rf_wdata, rf_rdata_a, rf_rdata_b;
    logic            unused_rsvd;

    assign ra_f        = RW'(instr_in[RA_MSB:RA_LSB]);
    assign rb_f        = RW'(instr_in[RB_MSB:RB_LSB]);
    assign unused_rsvd = instr_in[RSV_BIT];

    redux_regfile #(
        .BITS (BITS),
        .REGS (REGS),
        .RW   (RW)
    ) u_regfile (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .raddr_a  (ra_f),
        .raddr_b  (rb_f),
        .rdata_a  (rf_rdata_a),
        .rdata_b  (rf_rdata_b)
    );

    // Load path only writes in IDLE and writeback only in EXEC, so one port suffices
    always_comb begin
        state_nx        = state;
        instr_ready_out = 1'b0;
        accept          = 1'b0;
        rf_we           = 1'b0;
        rf_waddr        = load_reg_in;
        rf_wdata        = load_data_in;
        wb_valid_out    = 1'b0;
        busy_out        = 1'b1;
        case (state)
            IDLE: begin
                busy_out        = 1'b0;
                instr_ready_out = !load_en_in && rst_n_in;
                rf_we           = load_en_in;
                accept          = instr_valid_in && instr_ready_out;
                if (accept) begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                rf_we    = 1'b1;
                rf_waddr = ra_q;
                rf_wdata = ula_result_in;
                state_nx = WB;
            end
            WB: begin
                wb_valid_out = 1'b1;
                state_nx     = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state       <= IDLE;
            ra_q        <= '0;
            ula_op_out  <= '0;
            ula_a_out   <= '0;
            ula_b_out   <= '0;
            wb_reg_out  <= '0;
            wb_data_out <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                ra_q       <= ra_f;
                ula_op_out <= OP'(instr_in[OP_MSB:OP_LSB]);
                ula_a_out  <= rf_rdata_a;
                ula_b_out  <= rf_rdata_b;
            end
            if (state == EXEC) begin
                wb_reg_out  <= ra_q;
                wb_data_out <= ula_result_in;
            end
        end
    end

endmodule
